// File: rtl/mem_access_ctrl_pkg.sv
// arc_mem_pkg: shared types and constants for the ARC memory access controller
package arc_mem_pkg;
   typedef enum logic [2:0] {IDLE, READ, RWAIT, WRITE, ERR} state_t;
   localparam int ARC_WORD_W = 32;
   localparam logic [1:0] ARC_ALIGN_MASK = 2'b11;
endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: cpu-side request/ack handshake plus main_memory strobes
interface mem_access_ctrl_if
   import arc_mem_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = ARC_WORD_W
);
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_ready;
   logic          cpu_ack;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_err;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_rd;
   logic          mem_wr;
   logic [DW-1:0] mem_rdata;
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
      input  cpu_ready, cpu_ack, cpu_rdata, cpu_err, mem_addr, mem_wdata, mem_rd, mem_wr
   );
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
      output cpu_ready, cpu_ack, cpu_rdata, cpu_err, mem_addr, mem_wdata, mem_rd, mem_wr
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-word read/write sequencer for main_memory; MEM_ALIGN_CHECK_EN enables misaligned-access rejection
module mem_access_ctrl
   import arc_mem_pkg::*;
#(
   parameter int RD_LATENCY = 1,
   parameter int AW = 32,
   parameter int DW = ARC_WORD_W
) (
   input logic             clk,
   input logic             rst,
   mem_access_ctrl_if.slave bus
);
   localparam int CW = $clog2(RD_LATENCY + 1);
`ifdef MEM_ALIGN_CHECK_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif
   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          ack_n, err_n, rd_n, wr_n, accept, misaligned;
   logic [AW-1:0] addr_n;
   logic [DW-1:0] wdata_n, rdata_n;
   assign bus.cpu_ready = state == IDLE;
   assign accept = bus.cpu_req && bus.cpu_ready;
   assign misaligned = ALIGN_EN && (bus.cpu_addr[1:0] & ARC_ALIGN_MASK) != 2'b00;
   // next state and next values of every registered output
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      ack_n = 1'b0;
      err_n = 1'b0;
      rd_n = 1'b0;
      wr_n = 1'b0;
      addr_n = bus.mem_addr;
      wdata_n = bus.mem_wdata;
      rdata_n = bus.cpu_rdata;
      case (state)
         IDLE: if (accept) begin
            state_n = misaligned ? ERR : bus.cpu_we ? WRITE : READ;
            rd_n = !misaligned && !bus.cpu_we;
            wr_n = !misaligned && bus.cpu_we;
            addr_n = misaligned ? bus.mem_addr : bus.cpu_addr;
            wdata_n = (!misaligned && bus.cpu_we) ? bus.cpu_wdata : bus.mem_wdata;
         end
         READ: begin
            cnt_n = CW'(RD_LATENCY);
            state_n = RWAIT;
         end
         RWAIT: begin
            cnt_n = cnt != '0 ? cnt - CW'(1) : cnt;
            if (cnt == CW'(1)) begin
               rdata_n = bus.mem_rdata;
               ack_n = 1'b1;
               state_n = IDLE;
            end
         end
         WRITE: begin
            ack_n = 1'b1;
            state_n = IDLE;
         end
         ERR: begin
            ack_n = 1'b1;
            err_n = ALIGN_EN;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
   // state and output registers; reset aborts any access in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         bus.cpu_ack <= 1'b0;
         bus.cpu_err <= 1'b0;
         bus.cpu_rdata <= '0;
         bus.mem_addr <= '0;
         bus.mem_wdata <= '0;
         bus.mem_rd <= 1'b0;
         bus.mem_wr <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         bus.cpu_ack <= ack_n;
         bus.cpu_err <= err_n;
         bus.cpu_rdata <= rdata_n;
         bus.mem_addr <= addr_n;
         bus.mem_wdata <= wdata_n;
         bus.mem_rd <= rd_n;
         bus.mem_wr <= wr_n;
      end
   end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed checks of mem_access_ctrl at read latency 1 and 3
module tb_mem_access_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int compared = 0;
   int mismatched = 0;
   int ack_cnt = 0;
   int a0;
   logic overlap = 1'b0;
   logic [31:0] mem [0:1023];
   logic [31:0] d0, d1, d2;
   always #5 clk = ~clk;
   mem_access_ctrl_if #(.AW(32), .DW(32)) b1 ();
   mem_access_ctrl_if #(.AW(32), .DW(32)) b2 ();
   mem_access_ctrl #(.RD_LATENCY(1), .AW(32), .DW(32)) u1 (.clk(clk), .rst(rst), .bus(b1));
   mem_access_ctrl #(.RD_LATENCY(3), .AW(32), .DW(32)) u3 (.clk(clk), .rst(rst), .bus(b2));
   // main_memory model: registered read, delayed by two extra stages for the latency-3 port
   always @(posedge clk) begin
      if (rst) begin
         mem[512] <= 32'h81C02800;
         mem[513] <= 32'hC4002005;
      end else if (b1.mem_wr) mem[b1.mem_addr[11:2]] <= b1.mem_wdata;
      if (b1.mem_rd) b1.mem_rdata <= mem[b1.mem_addr[11:2]];
      if (b2.mem_rd) d0 <= mem[b2.mem_addr[11:2]];
      d1 <= d0;
      d2 <= d1;
   end
   assign b2.mem_rdata = d2;
   // watch for simultaneous strobes and count acknowledges mid-cycle
   always @(negedge clk) begin
      if ((b1.mem_rd && b1.mem_wr) || (b2.mem_rd && b2.mem_wr)) overlap <= 1'b1;
      if (b1.cpu_ack) ack_cnt <= ack_cnt + 1;
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic drive1(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      b1.cpu_req = req;
      b1.cpu_we = we;
      b1.cpu_addr = addr;
      b1.cpu_wdata = wdata;
   endtask
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   initial begin
      drive1(1'b0, 1'b0, 32'd0, 32'd0);
      b2.cpu_req = 1'b0;
      b2.cpu_we = 1'b0;
      b2.cpu_addr = 32'd0;
      b2.cpu_wdata = 32'd0;
      b1.mem_rdata = 32'd0;
      d0 = 32'd0;
      d1 = 32'd0;
      d2 = 32'd0;
      step();
      step();
      check("rst_ready", b1.cpu_ready, 1);
      check("rst_ack", b1.cpu_ack, 0);
      check("rst_err", b1.cpu_err, 0);
      check("rst_rdata", b1.cpu_rdata, 0);
      check("rst_addr", b1.mem_addr, 0);
      check("rst_wdata", b1.mem_wdata, 0);
      check("rst_rd", b1.mem_rd, 0);
      check("rst_wr", b1.mem_wr, 0);
      rst = 1'b0;
      step();
      drive1(1'b1, 1'b0, 32'd2048, 32'd0);
      step();
      b1.cpu_req = 1'b0;
      check("rd_strobe", b1.mem_rd, 1);
      check("rd_addr", b1.mem_addr, 2048);
      check("rd_busy", b1.cpu_ready, 0);
      step();
      check("rd_strobe_off", b1.mem_rd, 0);
      check("rd_no_early_ack", b1.cpu_ack, 0);
      step();
      check("rd_ack", b1.cpu_ack, 1);
      check("rd_data", b1.cpu_rdata, 32'h81C02800);
      check("rd_err", b1.cpu_err, 0);
      check("rd_ready", b1.cpu_ready, 1);
      step();
      check("rd_ack_pulse", b1.cpu_ack, 0);
      drive1(1'b1, 1'b1, 32'd2100, 32'h0000002A);
      step();
      check("wr_strobe", b1.mem_wr, 1);
      check("wr_wdata", b1.mem_wdata, 32'h2A);
      check("wr_no_rd", b1.mem_rd, 0);
      check("wr_no_early_ack", b1.cpu_ack, 0);
      drive1(1'b1, 1'b0, 32'd2100, 32'd0);
      step();
      check("wr_ack", b1.cpu_ack, 1);
      check("wr_ready", b1.cpu_ready, 1);
      check("wr_strobe_off", b1.mem_wr, 0);
      step();
      check("b2b_rd_strobe", b1.mem_rd, 1);
      check("b2b_ack_off", b1.cpu_ack, 0);
      b1.cpu_req = 1'b0;
      step();
      step();
      check("b2b_rd_ack", b1.cpu_ack, 1);
      check("b2b_rd_data", b1.cpu_rdata, 32'h2A);
      step();
      a0 = ack_cnt;
      drive1(1'b1, 1'b0, 32'd2048, 32'd0);
      step();
      step();
      check("hold_busy", b1.cpu_ready, 0);
      check("hold_no_rd", b1.mem_rd, 0);
      step();
      check("hold_ack", b1.cpu_ack, 1);
      check("hold_data", b1.cpu_rdata, 32'h81C02800);
      step();
      check("hold_reaccept", b1.mem_rd, 1);
      check("hold_ack_off", b1.cpu_ack, 0);
      b1.cpu_req = 1'b0;
      step();
      step();
      check("hold_ack2", b1.cpu_ack, 1);
      step();
      check("hold_ack_count", ack_cnt - a0, 2);
      drive1(1'b1, 1'b0, 32'd2049, 32'd0);
      step();
      b1.cpu_req = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      check("align_no_rd", b1.mem_rd, 0);
      check("align_no_early_ack", b1.cpu_ack, 0);
      step();
      check("align_ack", b1.cpu_ack, 1);
      check("align_err", b1.cpu_err, 1);
      check("align_rdata_kept", b1.cpu_rdata, 32'h81C02800);
      check("align_still_no_rd", b1.mem_rd, 0);
`else
      check("unalign_rd", b1.mem_rd, 1);
      check("unalign_addr", b1.mem_addr, 2049);
      step();
      step();
      check("unalign_ack", b1.cpu_ack, 1);
      check("unalign_err", b1.cpu_err, 0);
      check("unalign_data", b1.cpu_rdata, 32'h81C02800);
`endif
      step();
      check("err_pulse_off", b1.cpu_err, 0);
      b2.cpu_req = 1'b1;
      b2.cpu_we = 1'b0;
      b2.cpu_addr = 32'd2052;
      step();
      b2.cpu_req = 1'b0;
      check("lat3_rd", b2.mem_rd, 1);
      step();
      step();
      step();
      check("lat3_no_early_ack", b2.cpu_ack, 0);
      step();
      check("lat3_ack", b2.cpu_ack, 1);
      check("lat3_data", b2.cpu_rdata, 32'hC4002005);
      step();
      drive1(1'b1, 1'b0, 32'd2100, 32'd0);
      step();
      b1.cpu_req = 1'b0;
      step();
      rst = 1'b1;
      a0 = ack_cnt;
      step();
      check("abort_ack", b1.cpu_ack, 0);
      check("abort_ready", b1.cpu_ready, 1);
      check("abort_rdata", b1.cpu_rdata, 0);
      check("abort_addr", b1.mem_addr, 0);
      check("abort_rd", b1.mem_rd, 0);
      check("abort_wr", b1.mem_wr, 0);
      check("abort_err", b1.cpu_err, 0);
      rst = 1'b0;
      step();
      step();
      check("abort_no_late_ack", ack_cnt - a0, 0);
      check("no_rd_wr_overlap", overlap, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory access controller between the ARC datapath/control unit and `main_memory`. It accepts single-word read and write requests over a ready/ack handshake and drives `main_memory`'s `rd`/`wr`/`address`/`data_in` strobes. It waits out the memory's registered-read latency, then returns read data with a one-cycle acknowledge. Optionally, it rejects misaligned word accesses before they reach memory.

## Interface
- `RD_LATENCY`, default 1: edges from the `mem_rd` sample edge to valid `mem_rdata`. Must be ≥1.
- `AW`, default 32: address width.
- `DW`, default 32: data width.

Ports:
- `clk`  in  1  clock. All state changes on the rising edge.
- `rst`  in  1  reset. Synchronous, active-high.
- `cpu_req`  in  1  request valid.
- `cpu_we`  in  1  1 = write, 0 = read. Sampled with `cpu_req`.
- `cpu_addr`  in  AW  byte address. Passed to memory unchanged.
- `cpu_wdata`  in  DW  write data.
- `cpu_ready`  out  1  high only in IDLE. The request is accepted at an edge where `cpu_req && cpu_ready`.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  DW  read data. Valid while `cpu_ack` is high; held until the next read completes.
- `cpu_err`  out  1  high with `cpu_ack` when the access was rejected.
- `mem_addr`  out  AW  to `main_memory.address`.
- `mem_wdata`  out  DW  to `main_memory.data_in`.
- `mem_rd`  out  1  to `main_memory.rd`.
- `mem_wr`  out  1  to `main_memory.wr`.
- `mem_rdata`  in  DW  from `main_memory.data_out`.

## Operation
- States:
  - IDLE
  - READ
  - RWAIT
  - WRITE
  - ERR
- Outputs are registered except `cpu_ready`, which is decoded from state == IDLE.
- Transitions:
  - IDLE, accept, read: latch `cpu_addr` into `mem_addr`, go to READ.
  - IDLE, accept, write: latch `cpu_addr` into `mem_addr` and `cpu_wdata` into `mem_wdata`, go to WRITE.
  - IDLE, accept, rejected by the alignment check: go to ERR.
  - READ: `mem_rd` = 1 for exactly one cycle. Load the wait counter with `RD_LATENCY`, go to RWAIT.
  - RWAIT: decrement the counter each edge. At the edge where the counter reaches 1, capture `cpu_rdata` <= `mem_rdata`, pulse `cpu_ack`, and go to IDLE.
  - WRITE: `mem_wr` = 1 for exactly one cycle. At the next edge, pulse `cpu_ack` and go to IDLE.
  - ERR: no memory strobe. At the next edge, pulse `cpu_ack` with `cpu_err` = 1, go to IDLE. `cpu_rdata` is unchanged.
- `mem_rd` and `mem_wr` are never high together and never high outside READ/WRITE.
- `mem_addr` and `mem_wdata` hold their last latched values while idle.
- `cpu_req` while not ready is ignored. No queuing; the requester holds `cpu_req` until it sees `cpu_ready`.
- The wait counter is $clog2(RD_LATENCY+1) bits wide. It does not wrap and is reloaded on every READ.
- Reset values:
  - state = IDLE (so `cpu_ready` = 1 in the first cycle after the reset edge)
  - `cpu_ack` = 0, `cpu_err` = 0
  - `cpu_rdata` = 0
  - `mem_addr` = 0, `mem_wdata` = 0
  - `mem_rd` = 0, `mem_wr` = 0
  - counter = 0
- Reset mid-operation: the request is aborted with no `cpu_ack`, and strobes are low after the reset edge. A `mem_wr` already sampled by memory at that same edge is not undone. `rst` takes priority over `cpu_req`.

## Timing
- E0 is the accept edge.
- Write: `mem_wr` is high in the cycle after E0, and memory writes at E0+1. `cpu_ack` is high in the cycle after E0+1, and `cpu_ready` is high in that same cycle.
- Read: `mem_rd` is high in the cycle after E0, and memory registers `data_out` at E0+1. `cpu_rdata` and `cpu_ack` update at E0+1+RD_LATENCY. With the default, `cpu_ack` is high in the third cycle after E0.
- Back-to-back: a new request can be accepted in the cycle `cpu_ack` is high, at the next edge.
- Throughput: one write per 2 cycles; one read per 2+RD_LATENCY cycles.
- Error response: `cpu_ack` + `cpu_err` in the cycle after E0+1.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - A request with `cpu_addr[1:0]` != 0 goes to ERR.
  - No memory strobe is issued and `cpu_err` = 1.
- `MEM_ALIGN_CHECK_EN` undefined:
  - All addresses are forwarded unchanged.
  - ERR is unreachable and `cpu_err` is tied 0.

## Structure
- Package `arc_mem_pkg` holds:
  - the state enum
  - `ARC_WORD_W` = 32
  - `ARC_ALIGN_MASK` = 2'b11
- Single module. No sub-module is natural; the wait counter is inline.

## Test plan
- Reset, then read 2048 → `cpu_ack` in the third cycle after accept, `cpu_rdata` = 0x81C02800, `cpu_err` = 0.
- Write 0x0000002A to 2100, then read 2100 back-to-back → write ack at E0+1. Read returns 0x0000002A. `mem_rd` and `mem_wr` are never simultaneous.
- With `MEM_ALIGN_CHECK_EN`, read 2049 → `cpu_ack` = 1 and `cpu_err` = 1 one edge after accept. `mem_rd` stays 0 and `cpu_rdata` is unchanged.
- Hold `cpu_req` during a read in RWAIT → no second accept until `cpu_ready` = 1. Exactly one `cpu_ack` per accepted request.
- Assert `rst` in RWAIT → no `cpu_ack`. All outputs are at reset values and `cpu_ready` = 1 after the reset edge.
- With `RD_LATENCY` = 3, read 2052 → `cpu_ack` at E0+4 with 0xC4002005.
